// File: rtl/cau2_mux_arbiter.sv
// cau2_mux_arbiter
// Round-robin arbiter and select sequencer for an 8:1 single-bit mux.
// Grants one of eight requesters at a time, drives the mux select with the
// winner's index, and registers the mux output while a grant is active.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   req    in   [7:0] request vector, req[i] = requester i wants the mux
//   Y_in   in   mux output fed back from the 8:1 mux
//   S      out  [2:0] mux select = index of the granted requester
//   gnt    out  [7:0] one-hot grant, zero when idle
//   valid  out  grant active
//   Y_q    out  registered sample of Y_in taken during grant cycles
//
// state | meaning
// IDLE  | no grant; S keeps its last value
// GRANT | requester S owns the mux; hcnt counts consecutive cycles held
module cau2_mux_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       Y_in,
  output logic [2:0] S,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       Y_q
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] hcnt;

  logic       found;
  logic [2:0] win;
  logic [2:0] idx;

  // Circular scan starting at ptr; first set bit wins. Because ptr is
  // always S+1 after a grant, a lone holder is found again only after
  // every other index has been tried.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      S     <= 3'd0;
      gnt   <= 8'd0;
      valid <= 1'b0;
      Y_q   <= 1'b0;
      ptr   <= 3'd0;
      hcnt  <= 4'd0;
    end else begin
      // Sample belongs to the select that was active during the last cycle.
      if (valid) Y_q <= Y_in;

      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            S     <= win;
            gnt   <= 8'd1 << win;
            valid <= 1'b1;
            hcnt  <= 4'd1;
            ptr   <= win + 3'd1;
          end
        end
        GRANT: begin
          if (req[S] && (hcnt < HOLD_MAX)) begin
            hcnt <= hcnt + 4'd1;
          end else if (found) begin
            // Voluntary or forced release with a winner: hand over on this edge.
            S     <= win;
            gnt   <= 8'd1 << win;
            valid <= 1'b1;
            hcnt  <= 4'd1;
            ptr   <= win + 3'd1;
          end else begin
            state <= IDLE;
            gnt   <= 8'd0;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'd0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cau2_mux_arbiter.sv
module tb_cau2_mux_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mux_a = 8'hA5;

  // Instance with the default hold limit
  logic       rst0, y_in0, valid0, yq0;
  logic [7:0] req0, gnt0;
  logic [2:0] s0;
  assign y_in0 = mux_a[s0];

  cau2_mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst0), .req(req0), .Y_in(y_in0),
    .S(s0), .gnt(gnt0), .valid(valid0), .Y_q(yq0)
  );

  // Instance with MAX_HOLD=1 for pure rotation and feedback sampling
  logic       rst1, y_in1, valid1, yq1;
  logic [7:0] req1, gnt1;
  logic [2:0] s1;
  assign y_in1 = mux_a[s1];

  cau2_mux_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .Y_in(y_in1),
    .S(s1), .gnt(gnt1), .valid(valid1), .Y_q(yq1)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       valid;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] g,
                     input logic [2:0] s, input logic v, input string n);
    vec_t e;
    e.rst = r; e.req = rq; e.gnt = g; e.s = s; e.valid = v; e.name = n;
    vecs.push_back(e);
  endtask

  initial begin
    logic [7:0] yexp [8];
    int unsigned sidx;
    yexp = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};

    rst0 = 1'b1; req0 = 8'h00;
    rst1 = 1'b1; req1 = 8'h00;

    // Reset and single request
    add(1, 8'h00, 8'h00, 3'd0, 0, "reset");
    add(0, 8'h04, 8'h04, 3'd2, 1, "single_gnt");
    add(0, 8'h00, 8'h00, 3'd2, 0, "single_drop");
    // Voluntary release with a pending requester: no idle gap
    add(0, 8'h48, 8'h08, 3'd3, 1, "vol_first");
    add(0, 8'h40, 8'h40, 3'd6, 1, "vol_handoff");
    add(0, 8'h00, 8'h00, 3'd6, 0, "vol_idle");
    // Lone requester across two forced re-arbitrations
    for (int k = 0; k < 10; k++) add(0, 8'h20, 8'h20, 3'd5, 1, "lone");
    add(0, 8'h00, 8'h00, 3'd5, 0, "lone_idle");
    // Reset ignores req; then full contention rotates every 4 cycles
    add(1, 8'hFF, 8'h00, 3'd0, 0, "rst_ignores_req");
    for (int k = 0; k < 33; k++) begin
      sidx = (k / 4) % 8;
      add(0, 8'hFF, 8'd1 << sidx, 3'(sidx), 1, "rotate");
    end
    // Reset mid-grant, then 8'h81 grants 0 for 4 cycles then 7
    add(1, 8'hFF, 8'h00, 3'd0, 0, "rst_mid_grant");
    for (int k = 0; k < 4; k++) add(0, 8'h81, 8'h01, 3'd0, 1, "post_rst_0");
    add(0, 8'h81, 8'h80, 3'd7, 1, "post_rst_7");
    add(0, 8'h00, 8'h00, 3'd7, 0, "final_idle");

    @(negedge clk);
    foreach (vecs[i]) begin
      rst0 = vecs[i].rst;
      req0 = vecs[i].req;
      @(posedge clk); #1;
      chk({vecs[i].name, "_gnt"},   i, gnt0, vecs[i].gnt);
      chk({vecs[i].name, "_S"},     i, {5'd0, s0}, {5'd0, vecs[i].s});
      chk({vecs[i].name, "_valid"}, i, {7'd0, valid0}, {7'd0, vecs[i].valid});
    end

    // MAX_HOLD=1: pure rotation and feedback sampling lagging S by one cycle
    rst1 = 1'b1; req1 = 8'hFF;
    @(posedge clk); #1;
    chk("h1_rst_S", 0, {5'd0, s1}, 8'd0);
    chk("h1_rst_Yq", 0, {7'd0, yq1}, 8'd0);
    rst1 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      chk("h1_S", n, {5'd0, s1}, 8'((n - 1) % 8));
      chk("h1_gnt", n, gnt1, 8'd1 << ((n - 1) % 8));
      chk("h1_valid", n, {7'd0, valid1}, 8'd1);
      if (n == 1) chk("h1_Yq_first", n, {7'd0, yq1}, 8'd0);
      else if (n <= 9) chk("h1_Yq", n, {7'd0, yq1}, yexp[n - 2]);
    end
    // Lone requester under MAX_HOLD=1 is re-granted every cycle
    req1 = 8'h10;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("h1_lone_gnt", n, gnt1, 8'h10);
      chk("h1_lone_valid", n, {7'd0, valid1}, 8'd1);
    end
    req1 = 8'h00;
    @(posedge clk); #1;
    chk("h1_idle_valid", 0, {7'd0, valid1}, 8'd0);
    chk("h1_idle_S", 0, {5'd0, s1}, 8'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
